alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_core.sv | 90 +++++++++
 rtl/alu_pipe.sv | 97 +++++++++
 tb/tb_alu_pipe.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared constants for the pipelined ALU: opcode encodings and
//               the bit positions inside the 5-bit flags word
//               {op_err, neg, zero, carry, ovf}.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int unsigned c_nb_flags = 5;

    // Opcode encodings (6-bit, MIPS-style function codes)
    localparam logic [5:0] c_op_add = 6'b100000;
    localparam logic [5:0] c_op_sub = 6'b100010;
    localparam logic [5:0] c_op_and = 6'b100100;
    localparam logic [5:0] c_op_or  = 6'b100101;
    localparam logic [5:0] c_op_xor = 6'b100110;
    localparam logic [5:0] c_op_nor = 6'b100111;
    localparam logic [5:0] c_op_srl = 6'b000010;
    localparam logic [5:0] c_op_sra = 6'b000011;

    // Flag bit indices
    localparam int unsigned c_flag_ovf    = 0;
    localparam int unsigned c_flag_carry  = 1;
    localparam int unsigned c_flag_zero   = 2;
    localparam int unsigned c_flag_neg    = 3;
    localparam int unsigned c_flag_op_err = 4;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_core
// Description : Purely combinational ALU datapath. Computes the result and
//               the {op_err, neg, zero, carry, ovf} flags for one operation.
// Ports       : i_dato_a  - first operand
//               i_dato_b  - second operand / unsigned shift amount
//               i_opcode  - operation select
//               o_result  - result
//               o_flags   - status flags
// Revision    : 1.0 - initial release
// ============================================================================
module alu_core
    import alu_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic [NB_DATA-1:0]    i_dato_a,
    input  logic [NB_DATA-1:0]    i_dato_b,
    input  logic [NB_OPCODE-1:0]  i_opcode,
    output logic [NB_DATA-1:0]    o_result,
    output logic [c_nb_flags-1:0] o_flags
);

    // NB_DATA always fits in NB_DATA bits because NB_DATA >= 4
    localparam logic [NB_DATA-1:0] c_shift_limit = NB_DATA'(NB_DATA);

    logic [NB_DATA:0]   w_sum;
    logic [NB_DATA:0]   w_diff;
    logic [NB_DATA-1:0] w_res;
    logic               w_carry;
    logic               w_ovf;
    logic               w_err;
    logic               w_big_shift;
    logic               w_a_msb;
    logic               w_b_msb;

    assign w_sum       = {1'b0, i_dato_a} + {1'b0, i_dato_b};
    // Top bit of the extended difference is the unsigned borrow
    assign w_diff      = {1'b0, i_dato_a} - {1'b0, i_dato_b};
    assign w_big_shift = (i_dato_b >= c_shift_limit);
    assign w_a_msb     = i_dato_a[NB_DATA-1];
    assign w_b_msb     = i_dato_b[NB_DATA-1];

    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (i_opcode)
            NB_OPCODE'(c_op_add): begin
                w_res   = w_sum[NB_DATA-1:0];
                w_carry = w_sum[NB_DATA];
                // Same-sign operands producing an opposite-sign result
                w_ovf   = (w_a_msb == w_b_msb) && (w_sum[NB_DATA-1] != w_a_msb);
            end
            NB_OPCODE'(c_op_sub): begin
                w_res   = w_diff[NB_DATA-1:0];
                w_carry = w_diff[NB_DATA];
                w_ovf   = (w_a_msb != w_b_msb) && (w_diff[NB_DATA-1] != w_a_msb);
            end
            NB_OPCODE'(c_op_and): w_res = i_dato_a & i_dato_b;
            NB_OPCODE'(c_op_or):  w_res = i_dato_a | i_dato_b;
            NB_OPCODE'(c_op_xor): w_res = i_dato_a ^ i_dato_b;
            NB_OPCODE'(c_op_nor): w_res = ~(i_dato_a | i_dato_b);
            NB_OPCODE'(c_op_srl): begin
                w_res = w_big_shift ? '0 : (i_dato_a >> i_dato_b);
            end
            NB_OPCODE'(c_op_sra): begin
                w_res = w_big_shift ? {NB_DATA{w_a_msb}}
                                    : $unsigned($signed(i_dato_a) >>> i_dato_b);
            end
            default: w_err = 1'b1;
        endcase
    end

    always_comb begin
        o_flags                = '0;
        o_flags[c_flag_ovf]    = w_ovf;
        o_flags[c_flag_carry]  = w_carry;
        o_flags[c_flag_zero]   = (w_res == '0);
        o_flags[c_flag_neg]    = w_res[NB_DATA-1];
        o_flags[c_flag_op_err] = w_err;
    end

    assign o_result = w_res;

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe
// Description : Two-stage valid/ready ALU pipeline. Stage 1 registers the
//               operands and opcode, stage 2 registers result and flags.
//               One operation per cycle, two cycles of latency.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - input handshake
//               dato_a, dato_b      - operands (dato_b = shift amount)
//               opcode              - operation select
//               out_valid/out_ready - output handshake
//               out, flags          - result, {op_err, neg, zero, carry, ovf}
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe
    import alu_pkg::*;
#(
    parameter int NB_DATA   = 8,
    parameter int NB_OPCODE = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NB_DATA-1:0]    dato_a,
    input  logic [NB_DATA-1:0]    dato_b,
    input  logic [NB_OPCODE-1:0]  opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NB_DATA-1:0]    out,
    output logic [c_nb_flags-1:0] flags
);

    logic                  r_s1_valid;
    logic [NB_DATA-1:0]    r_s1_a;
    logic [NB_DATA-1:0]    r_s1_b;
    logic [NB_OPCODE-1:0]  r_s1_op;
    logic                  r_s2_valid;
    logic [NB_DATA-1:0]    r_out;
    logic [c_nb_flags-1:0] r_flags;

    logic [NB_DATA-1:0]    w_res;
    logic [c_nb_flags-1:0] w_flags;
    logic                  w_s2_load;
    logic                  w_s1_load;

    // A stage may load when it is empty or its contents leave this cycle
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_load = !r_s1_valid || w_s2_load;
    assign in_ready  = !rst && w_s1_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_s1_load) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_a  <= dato_a;
                r_s1_b  <= dato_b;
                r_s1_op <= opcode;
            end
        end
    end

    alu_core #(
        .NB_DATA   (NB_DATA),
        .NB_OPCODE (NB_OPCODE)
    ) u_alu_core (
        .i_dato_a (r_s1_a),
        .i_dato_b (r_s1_b),
        .i_opcode (r_s1_op),
        .o_result (w_res),
        .o_flags  (w_flags)
    );

    // Result registers only change on a load with a valid operation, so the
    // output holds steady while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_out      <= '0;
            r_flags    <= '0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out   <= w_res;
                r_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign out       = r_out;
    assign flags     = r_flags;

endmodule : alu_pipe
`default_nettype wire

// File: tb/tb_alu_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe
// Description : Directed self-checking testbench for alu_pipe (NB_DATA = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe;

    localparam int NB_DATA   = 8;
    localparam int NB_OPCODE = 6;

    logic                 clk;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [NB_DATA-1:0]   dato_a;
    logic [NB_DATA-1:0]   dato_b;
    logic [NB_OPCODE-1:0] opcode;
    logic                 out_valid;
    logic                 out_ready;
    logic [NB_DATA-1:0]   out;
    logic [4:0]           flags;

    int n_checks = 0;
    int n_errors = 0;

    alu_pipe #(
        .NB_DATA   (NB_DATA),
        .NB_OPCODE (NB_OPCODE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dato_a    (dato_a),
        .dato_b    (dato_b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Directed vectors: opcode, a, b, expected out, expected flags {err,neg,zero,carry,ovf}
    typedef struct packed {
        logic [5:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [4:0] flg;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    initial begin
        vecs[0]  = '{6'b100000, 8'h7F, 8'h01, 8'h80, 5'b01001}; // ADD signed overflow
        vecs[1]  = '{6'b100010, 8'h00, 8'h01, 8'hFF, 5'b01010}; // SUB borrow
        vecs[2]  = '{6'b100000, 8'hFF, 8'h01, 8'h00, 5'b00110}; // ADD carry, zero
        vecs[3]  = '{6'b000011, 8'h80, 8'h03, 8'hF0, 5'b01000}; // SRA
        vecs[4]  = '{6'b000010, 8'h80, 8'h03, 8'h10, 5'b00000}; // SRL
        vecs[5]  = '{6'b000011, 8'h80, 8'h09, 8'hFF, 5'b01000}; // SRA amount > width
        vecs[6]  = '{6'b000010, 8'h80, 8'h08, 8'h00, 5'b00100}; // SRL amount = width
        vecs[7]  = '{6'b111111, 8'hA5, 8'h5A, 8'h00, 5'b10100}; // illegal opcode
        vecs[8]  = '{6'b100100, 8'hF0, 8'h3C, 8'h30, 5'b00000}; // AND
        vecs[9]  = '{6'b100101, 8'hF0, 8'h0F, 8'hFF, 5'b01000}; // OR
        vecs[10] = '{6'b100110, 8'hFF, 8'hFF, 8'h00, 5'b00100}; // XOR
        vecs[11] = '{6'b100111, 8'h00, 8'h00, 8'hFF, 5'b01000}; // NOR
        vecs[12] = '{6'b100010, 8'h80, 8'h01, 8'h7F, 5'b00001}; // SUB signed overflow
        vecs[13] = '{6'b000011, 8'h40, 8'h02, 8'h10, 5'b00000}; // SRA positive
        vecs[14] = '{6'b000010, 8'h80, 8'h07, 8'h01, 5'b00000}; // SRL max legal amount
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        dato_a    = '0;
        dato_b    = '0;
        opcode    = '0;
        out_ready = 1'b1;

        // ---------------- Reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out",       32'(out),       32'd0);
        check("rst_flags",     32'(flags),     32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // ---------------- Streamed directed vectors, one per cycle ----------------
        for (int i = 0; i < NV + 2; i++) begin
            @(negedge clk);
            if (i == 1) check("latency_not_1", 32'(out_valid), 32'd0);
            if (i >= 2) begin
                check($sformatf("v%0d_valid", i - 2), 32'(out_valid), 32'd1);
                check($sformatf("v%0d_out",   i - 2), 32'(out),       32'(vecs[i-2].res));
                check($sformatf("v%0d_flags", i - 2), 32'(flags),     32'(vecs[i-2].flg));
            end
            if (i < NV) begin
                check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
                in_valid = 1'b1;
                opcode   = vecs[i].op;
                dato_a   = vecs[i].a;
                dato_b   = vecs[i].b;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("drain_valid", 32'(out_valid), 32'd0);

        // ---------------- Backpressure: three back-to-back ops ----------------
        out_ready = 1'b0;
        check("bp_rdy_a", 32'(in_ready), 32'd1);
        in_valid = 1'b1; opcode = 6'b100000; dato_a = 8'h10; dato_b = 8'h20;   // -> 30
        @(negedge clk);
        check("bp_rdy_b", 32'(in_ready), 32'd1);
        opcode = 6'b100010; dato_a = 8'h50; dato_b = 8'h10;                     // -> 40
        @(negedge clk);
        opcode = 6'b100100; dato_a = 8'hFF; dato_b = 8'h0F;                     // -> 0F
        for (int k = 0; k < 3; k++) begin
            check("bp_rdy_c_blocked", 32'(in_ready),  32'd0);
            check("bp_hold_valid",    32'(out_valid), 32'd1);
            check("bp_hold_out",      32'(out),       32'h30);
            check("bp_hold_flags",    32'(flags),     32'h00);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_rdy_c_release", 32'(in_ready), 32'd1);
        check("bp_out_a",         32'(out),      32'h30);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_valid_b", 32'(out_valid), 32'd1);
        check("bp_out_b",   32'(out),       32'h40);
        @(negedge clk);
        check("bp_valid_c", 32'(out_valid), 32'd1);
        check("bp_out_c",   32'(out),       32'h0F);
        @(negedge clk);
        check("bp_empty", 32'(out_valid), 32'd0);

        // ---------------- Reset with both stages full ----------------
        out_ready = 1'b0;
        in_valid = 1'b1; opcode = 6'b100000; dato_a = 8'h01; dato_b = 8'h01;
        @(negedge clk);
        dato_a = 8'h02;
        @(negedge clk);
        in_valid = 1'b0;
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_out",   32'(out),       32'h02);
        rst = 1'b1;
        #1;
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_out",   32'(out),       32'd0);
        check("rst_mid_flags", 32'(flags),     32'd0);
        #1;
        check("rst_mid_in_ready_after", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("no_stale_result", 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_pipe
`default_nettype wire
